adc_scan_sequencer: RTL and testbench
=====================================

// Module: adc_scan_sequencer
// PURPOSE
//  Sequences the board's 8-channel 12-bit serial ADC (ADC128S022-type SPI: CS_n, SCLK, DIN, DOUT).
//  Scans the channels selected by a mask, single-shot or continuously, and keeps the latest result per channel.
//  Nios II reads and controls it through an Avalon-MM slave in the platform; the ADC pins go to top level.
// PARAMETERS
//  CLK_DIV  8   SCLK half-period in clk_clk cycles; 8 gives 3.125 MHz SCLK at 50 MHz. Legal range 2..255.
//  NUM_CH   8   number of ADC channels; the address field is 3 bits.
//  DATA_W   12  conversion width.
// PORTS
//  clk_clk        in   1   system clock, 50 MHz
//  reset_reset_n  in   1   asynchronous active-low reset
//  avs_address    in   4   word address
//  avs_read       in   1   read strobe
//  avs_write      in   1   write strobe
//  avs_writedata  in   32  write data
//  avs_readdata   out  32  read data, registered, 1-cycle latency
//  adc_cs_n       out  1   ADC chip select
//  adc_sclk       out  1   ADC serial clock; idles high
//  adc_din        out  1   channel address to the ADC
//  adc_dout       in   1   conversion data from the ADC
//  busy           out  1   scan in progress
// BEHAVIOUR
//  Register map:
//   0x0 CTRL     [0] run (continuous); [1] start (single-shot, write-only, self-clears); [15:8] channel mask.
//   0x1 STATUS   [0] busy; [1] done, sticky, write 1 to clear.
//   0x8+n RES_n  [11:0] channel n data; [16] valid, cleared only by reset. Other bits read 0.
//  Unmapped addresses read 0; writes to them are ignored.
//  Reset values: adc_cs_n=1, adc_sclk=1, adc_din=0, busy=0, avs_readdata=0. All registers reset to 0.
//  FSM states: IDLE -> CS_SETUP (1 half-period) -> SHIFT (16 SCLK cycles) -> STORE (1 clk) -> SHIFT | CS_HOLD.
//   CS_HOLD holds CS_n high for 2 half-periods, then goes to IDLE, or to CS_SETUP when run=1.
//  Scan start:
//   - Condition: IDLE and (start or run) and mask != 0.
//   - The mask is latched at scan start. CTRL writes during a scan affect the next scan only.
//  Frame protocol:
//   - DIN changes on the SCLK falling edge, MSB first. Frame bits 2..4 carry ADD2..0.
//   - DOUT is sampled on the SCLK rising edge. Frame bits 4..15 are data, MSB first.
//  Pipelining:
//   - Frame k sends the address of the next enabled channel, in ascending order.
//   - Frame k returns data for the address sent in frame k-1.
//   - A scan of N enabled channels takes N+1 frames; frame 0 data is discarded.
//   - CS_n stays low for the whole scan.
//  STORE writes RES_n as one 32-bit update, so no read ever sees a torn value.
//   A read in the same cycle as STORE returns the old value.
//  Scan end: done is set when the scan's last STORE completes. If done is set and cleared in the same cycle, set wins.
//  Control edge cases:
//   - run cleared mid-scan: the current scan finishes, then the FSM returns to IDLE.
//   - start while busy: ignored.
//   - start with mask == 0: ignored; done is not set.
//  busy = 1 from leaving IDLE until re-entering IDLE. In continuous mode it stays 1 across back-to-back scans.
//  Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). The partial frame is lost.
// CONFIGURATION
//  ADC_SEQ_IRQ_EN defined:
//   - Adds port irq (out, 1); irq = done & CTRL[2]. CTRL[2] is the IRQ enable, read/write, reset 0.
//   - irq stays asserted until done is cleared through STATUS.
//  ADC_SEQ_IRQ_EN undefined: no irq port; CTRL[2] reads 0 and writes to it are ignored.
// TESTING
//  1. Reset; read all registers -> every value 0; adc_cs_n=1, adc_sclk=1.
//  2. Model returns 0xA5C for ch3; write CTRL=0x0000_0802 -> 2 frames; RES_3=0x0001_0A5C; STATUS=0x2; DIN frame 0 bits 2..4 = 011.
//  3. Mask 0x81, model returns ch0=0x123, ch7=0xFFF -> RES_0=0x10123, RES_7=0x10FFF; ch7 address is sent in frame 1.
//  4. CTRL=0x0000_FF01 -> back-to-back scans, busy stays 1; write CTRL=0x0000_FF00 mid-scan -> scan completes, then IDLE.
//  5. Write start while busy, and start with mask=0 -> no new frame; done unchanged.
//  6. Deassert reset_reset_n mid-SHIFT -> adc_cs_n=1 and adc_sclk=1 with no clock edge. With ADC_SEQ_IRQ_EN: irq on done; W1C on STATUS drops irq.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for an 8-channel 12-bit SPI ADC (ADC128S022 style) behind an Avalon-MM slave.
// Optional feature macro: ADC_SEQ_IRQ_EN adds the irq output and the CTRL[2] interrupt enable.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | CS_n high, waiting for start/run with a non-zero mask
// S_CS_SETUP | CS_n low for one half-period before the first SCLK fall
// S_SHIFT    | 16 SCLK cycles: DIN driven on fall, DOUT sampled on rise
// S_STORE    | one clk: commit the previous channel's result
// S_CS_HOLD  | CS_n high for two half-periods between scans

module adc_scan_sequencer #(
    parameter int CLK_DIV = 8,
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 12
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
`ifdef ADC_SEQ_IRQ_EN
    output logic        irq,
`endif
    output logic        busy
);

    localparam logic [7:0] TMR_LOAD = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_STORE,
        S_CS_HOLD
    } state_t;

    state_t state, state_nxt;

    logic              run_q;
    logic [NUM_CH-1:0] mask_q;
    logic              start_q;
    logic              done_q;
`ifdef ADC_SEQ_IRQ_EN
    logic              irq_en_q;
`endif

    logic [7:0]        tmr;
    logic              tc;
    logic              hold_half;
    logic [NUM_CH-1:0] rem;
    logic [2:0]        tx_ch;
    logic [2:0]        rx_ch;
    logic              tx_valid;
    logic              rx_valid;
    logic [15:0]       tx_sr;
    logic [15:0]       rx_sr;
    logic [3:0]        bit_cnt;
    logic              scan_go;
    logic              frame_go;
    logic [2:0]        first_ch;
    logic [NUM_CH-1:0] first_oh;

    logic [DATA_W-1:0] res_data [NUM_CH];
    logic [NUM_CH-1:0] res_valid;

    logic              wr_ctrl;
    logic              wr_status;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign wr_ctrl   = avs_write && (avs_address == 4'h0);
    assign wr_status = avs_write && (avs_address == 4'h1);
    assign tc        = (tmr == 8'd0);
    assign busy      = (state != S_IDLE);

`ifdef ADC_SEQ_IRQ_EN
    assign irq = done_q & irq_en_q;
    assign unused_bits = ^{avs_writedata[31:16], avs_writedata[7:3], rx_sr[15]};
`else
    assign unused_bits = ^{avs_writedata[31:16], avs_writedata[7:2], rx_sr[15]};
`endif

    // Lowest still-pending channel gives ascending scan order.
    always_comb begin
        first_ch = '0;
        first_oh = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rem[i]) begin
                first_ch    = 3'(i);
                first_oh    = '0;
                first_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scan_go   = 1'b0;
        frame_go  = 1'b0;
        case (state)
            S_IDLE: begin
                if ((start_q || run_q) && (|mask_q)) begin
                    state_nxt = S_CS_SETUP;
                    scan_go   = 1'b1;
                end
            end
            S_CS_SETUP: begin
                if (tc) begin
                    state_nxt = S_SHIFT;
                    frame_go  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (tc && !adc_sclk && (bit_cnt == 4'd15)) begin
                    state_nxt = S_STORE;
                end
            end
            S_STORE: begin
                if (tx_valid) begin
                    state_nxt = S_SHIFT;
                    frame_go  = 1'b1;
                end else begin
                    state_nxt = S_CS_HOLD;
                end
            end
            S_CS_HOLD: begin
                if (tc && hold_half) begin
                    if (run_q && (|mask_q)) begin
                        state_nxt = S_CS_SETUP;
                        scan_go   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Half-period timer, reloaded on every state change and at terminal count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tmr       <= '0;
            hold_half <= 1'b0;
        end else begin
            if ((state_nxt != state) || tc) begin
                tmr <= TMR_LOAD;
            end else begin
                tmr <= tmr - 8'd1;
            end
            if (state != S_CS_HOLD) begin
                hold_half <= 1'b0;
            end else if (tc) begin
                hold_half <= 1'b1;
            end
        end
    end

    // adc_dout needs no synchronizer: it settles a full half-period before the rising SCLK sample.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
        end else begin
            adc_cs_n <= (state_nxt == S_IDLE) || (state_nxt == S_CS_HOLD);
            if (state == S_SHIFT && tc) begin
                adc_sclk <= ~adc_sclk;
            end else if (state != S_SHIFT) begin
                adc_sclk <= 1'b1;
            end
            if (frame_go) begin
                tx_sr   <= {2'b00, first_ch, 11'b0};
                bit_cnt <= '0;
            end else if (state == S_SHIFT && tc && adc_sclk) begin
                adc_din <= tx_sr[15];
                tx_sr   <= {tx_sr[14:0], 1'b0};
            end else if (state == S_SHIFT && tc && !adc_sclk) begin
                rx_sr   <= {rx_sr[14:0], adc_dout};
                bit_cnt <= bit_cnt + 4'd1;
            end else if (state_nxt == S_IDLE) begin
                adc_din <= 1'b0;
            end
        end
    end

    // Channel pipeline: the frame that sends an address returns the data one frame later.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rem      <= '0;
            tx_ch    <= '0;
            rx_ch    <= '0;
            tx_valid <= 1'b0;
            rx_valid <= 1'b0;
        end else if (scan_go) begin
            rem      <= mask_q;
            tx_valid <= 1'b0;
            rx_valid <= 1'b0;
        end else if (frame_go) begin
            rx_ch    <= tx_ch;
            rx_valid <= tx_valid;
            tx_ch    <= first_ch;
            tx_valid <= |rem;
            rem      <= rem & ~first_oh;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            res_valid <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                res_data[i] <= '0;
            end
        end else if (state == S_STORE && rx_valid) begin
            res_data[rx_ch]  <= rx_sr[DATA_W-1:0];
            res_valid[rx_ch] <= 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            run_q    <= 1'b0;
            mask_q   <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef ADC_SEQ_IRQ_EN
            irq_en_q <= 1'b0;
`endif
        end else begin
            start_q <= wr_ctrl && avs_writedata[1];
            if (wr_ctrl) begin
                run_q  <= avs_writedata[0];
                mask_q <= avs_writedata[8 +: NUM_CH];
`ifdef ADC_SEQ_IRQ_EN
                irq_en_q <= avs_writedata[2];
`endif
            end
            // Set has priority over a simultaneous write-1-to-clear.
            if (state == S_STORE && !tx_valid) begin
                done_q <= 1'b1;
            end else if (wr_status && avs_writedata[1]) begin
                done_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            4'h0: begin
                rd_mux[0]             = run_q;
                rd_mux[8 +: NUM_CH]   = mask_q;
`ifdef ADC_SEQ_IRQ_EN
                rd_mux[2]             = irq_en_q;
`endif
            end
            4'h1: begin
                rd_mux[0] = busy;
                rd_mux[1] = done_q;
            end
            default: begin
                if (avs_address[3] && (32'(avs_address[2:0]) < NUM_CH)) begin
                    rd_mux[DATA_W-1:0] = res_data[avs_address[2:0]];
                    rd_mux[16]         = res_valid[avs_address[2:0]];
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else begin
            avs_readdata <= avs_read ? rd_mux : 32'h0;
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC128S022-style slave model.
// Builds with or without ADC_SEQ_IRQ_EN.

module tb_adc_scan_sequencer;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic        adc_dout;
    logic        busy;
`ifdef ADC_SEQ_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_errors = 0;

    adc_scan_sequencer dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .adc_cs_n      (adc_cs_n),
        .adc_sclk      (adc_sclk),
        .adc_din       (adc_din),
        .adc_dout      (adc_dout),
`ifdef ADC_SEQ_IRQ_EN
        .irq           (irq),
`endif
        .busy          (busy)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // ADC slave model, sampled on the falling clk edge so it never races the DUT flops.
    logic [11:0] chan_val [8];
    logic [2:0]  addr_log [16];
    logic [2:0]  addr_cur;
    logic [2:0]  addr_prev;
    logic [15:0] out_word;
    logic        prev_cs;
    logic        prev_sclk;
    logic        prev_busy;
    int          rise_idx;
    int          frame_in_scan;
    int          scan_cnt;
    int          busy_falls;

    initial begin
        for (int i = 0; i < 8; i++) chan_val[i] = 12'h000;
        for (int i = 0; i < 16; i++) addr_log[i] = 3'd0;
        addr_cur      = 3'd0;
        addr_prev     = 3'd0;
        out_word      = 16'h0;
        rise_idx      = 0;
        frame_in_scan = 0;
        scan_cnt      = 0;
        busy_falls    = 0;
        prev_cs       = 1'b1;
        prev_sclk     = 1'b1;
        prev_busy     = 1'b0;
        adc_dout      = 1'b0;
    end

    always @(negedge clk_clk) begin
        if (reset_reset_n !== 1'b1) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            prev_busy = 1'b0;
            rise_idx  = 0;
            adc_dout  = 1'b0;
        end else begin
            if (prev_cs && !adc_cs_n) begin
                scan_cnt++;
                frame_in_scan = 0;
                rise_idx      = 0;
            end
            if (!adc_cs_n && prev_sclk && !adc_sclk) begin
                if (rise_idx == 0) out_word = {4'b0000, chan_val[addr_prev]};
                adc_dout = out_word[15 - rise_idx];
            end
            if (!adc_cs_n && !prev_sclk && adc_sclk) begin
                if (rise_idx >= 2 && rise_idx <= 4) addr_cur[4 - rise_idx] = adc_din;
                rise_idx++;
                if (rise_idx == 16) begin
                    if (frame_in_scan < 16) addr_log[frame_in_scan] = addr_cur;
                    addr_prev = addr_cur;
                    frame_in_scan++;
                    rise_idx = 0;
                end
            end
            if (prev_busy && !busy) busy_falls++;
            prev_cs   = adc_cs_n;
            prev_sclk = adc_sclk;
            prev_busy = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk_clk);
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk_clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk_clk);
        avs_read = 1'b0;
        d        = avs_readdata;
        check(tag, d, exp);
    endtask

    task automatic wait_busy(input string tag, input int max);
        int n = 0;
        while (busy !== 1'b1 && n < max) begin
            @(negedge clk_clk);
            n++;
        end
        if (n >= max) check({tag, "_busy_timeout"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk_clk);
            n++;
        end
        if (n >= max) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    int base_scan;
    int base_falls;

    initial begin
        reset_reset_n = 1'b0;
        avs_address   = 4'h0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        repeat (4) @(negedge clk_clk);

        // 1: reset state
        check("rst_cs_n", 32'(adc_cs_n), 32'd1);
        check("rst_sclk", 32'(adc_sclk), 32'd1);
        check("rst_din", 32'(adc_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", avs_readdata, 32'h0);
        reset_reset_n = 1'b1;
        read_check("rst_ctrl", 4'h0, 32'h0);
        read_check("rst_status", 4'h1, 32'h0);
        read_check("rst_unmapped", 4'h5, 32'h0);
        for (int i = 8; i < 16; i++) read_check($sformatf("rst_res%0d", i - 8), 4'(i), 32'h0);

        // 2: single channel 3
        chan_val[3] = 12'hA5C;
        base_scan = scan_cnt;
        bus_write(4'h0, 32'h0000_0802);
        wait_busy("t2", 50);
        wait_idle("t2", 3000);
        check("t2_scans", 32'(scan_cnt - base_scan), 32'd1);
        check("t2_frames", 32'(frame_in_scan), 32'd2);
        check("t2_addr_f0", 32'(addr_log[0]), 32'd3);
        read_check("t2_res3", 4'hB, 32'h0001_0A5C);
        read_check("t2_status", 4'h1, 32'h2);
        read_check("t2_ctrl", 4'h0, 32'h0000_0800);
        bus_write(4'h1, 32'h2);
        read_check("t2_w1c", 4'h1, 32'h0);

        // 3: channels 0 and 7
        chan_val[0] = 12'h123;
        chan_val[7] = 12'hFFF;
        bus_write(4'h0, 32'h0000_8102);
        wait_busy("t3", 50);
        wait_idle("t3", 4000);
        check("t3_frames", 32'(frame_in_scan), 32'd3);
        check("t3_addr_f0", 32'(addr_log[0]), 32'd0);
        check("t3_addr_f1", 32'(addr_log[1]), 32'd7);
        read_check("t3_res0", 4'h8, 32'h0001_0123);
        read_check("t3_res7", 4'hF, 32'h0001_0FFF);
        read_check("t3_res3_kept", 4'hB, 32'h0001_0A5C);
        read_check("t3_res1_empty", 4'h9, 32'h0);

        // 4: continuous mode, then run cleared mid-scan
        for (int i = 0; i < 8; i++) chan_val[i] = {4'(i), 8'h5A};
        base_scan  = scan_cnt;
        base_falls = busy_falls;
        bus_write(4'h0, 32'h0000_FF01);
        begin
            int n = 0;
            while ((scan_cnt - base_scan) < 2 && n < 8000) begin
                @(negedge clk_clk);
                n++;
            end
            if (n >= 8000) check("t4_second_scan_timeout", 32'(scan_cnt - base_scan), 32'd2);
        end
        check("t4_busy_between", 32'(busy_falls - base_falls), 32'd0);
        bus_write(4'h0, 32'h0000_FF00);
        wait_idle("t4", 6000);
        repeat (100) @(negedge clk_clk);
        check("t4_scans", 32'(scan_cnt - base_scan), 32'd2);
        check("t4_busy_falls", 32'(busy_falls - base_falls), 32'd1);
        check("t4_frames", 32'(frame_in_scan), 32'd9);
        check("t4_addr_f7", 32'(addr_log[7]), 32'd7);
        read_check("t4_res5", 4'hD, 32'h0001_055A);
        read_check("t4_res0", 4'h8, 32'h0001_005A);
        read_check("t4_status", 4'h1, 32'h2);

        // 5: start while busy, and start with an empty mask
        bus_write(4'h1, 32'h2);
        base_scan = scan_cnt;
        bus_write(4'h0, 32'h0000_0102);
        wait_busy("t5", 50);
        bus_write(4'h0, 32'h0000_0102);
        wait_idle("t5", 3000);
        repeat (300) @(negedge clk_clk);
        check("t5_busy_start_scans", 32'(scan_cnt - base_scan), 32'd1);
        check("t5_frames", 32'(frame_in_scan), 32'd2);
        read_check("t5_status_done", 4'h1, 32'h2);
        bus_write(4'h1, 32'h2);
        base_scan = scan_cnt;
        bus_write(4'h0, 32'h0000_0002);
        repeat (300) @(negedge clk_clk);
        check("t5_mask0_scans", 32'(scan_cnt - base_scan), 32'd0);
        check("t5_mask0_busy", 32'(busy), 32'd0);
        read_check("t5_mask0_status", 4'h1, 32'h0);

        // IRQ enable bit and, when present, the irq output
        bus_write(4'h0, 32'h0000_0104);
`ifdef ADC_SEQ_IRQ_EN
        read_check("irq_en_ctrl", 4'h0, 32'h0000_0104);
        check("irq_idle", 32'(irq), 32'd0);
        bus_write(4'h0, 32'h0000_0106);
        wait_busy("irq", 50);
        wait_idle("irq", 3000);
        check("irq_on_done", 32'(irq), 32'd1);
        bus_write(4'h1, 32'h2);
        check("irq_w1c", 32'(irq), 32'd0);
`else
        read_check("irq_en_ctrl", 4'h0, 32'h0000_0100);
`endif

        // 6: reset asserted mid-SHIFT
        bus_write(4'h0, 32'h0000_FF02);
        begin
            int n = 0;
            while (adc_sclk !== 1'b0 && n < 2000) begin
                @(negedge clk_clk);
                n++;
            end
            if (n >= 2000) check("t6_sclk_low_timeout", 32'(adc_sclk), 32'd0);
        end
        check("t6_in_shift_cs", 32'(adc_cs_n), 32'd0);
        @(posedge clk_clk);
        #3;
        reset_reset_n = 1'b0;
        #1;
        check("t6_async_cs_n", 32'(adc_cs_n), 32'd1);
        check("t6_async_sclk", 32'(adc_sclk), 32'd1);
        check("t6_async_din", 32'(adc_din), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        read_check("t6_res0", 4'h8, 32'h0);
        read_check("t6_ctrl", 4'h0, 32'h0);
        read_check("t6_status", 4'h1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
